// File: rtl/mbldcm_dead_time_inserter_pkg.sv
// Shared definitions for the BLDC gate-drive path: leg state encodings,
// request decode and helpers used by the dead-time inserter and its legs.
package mbldcm_dead_time_inserter_pkg;

    localparam int NUM_LEGS = 3;
    localparam int LEG_U    = 0;
    localparam int LEG_V    = 1;
    localparam int LEG_W    = 2;

    typedef enum logic [1:0] {
        LEG_OFF  = 2'd0,
        LEG_ON_H = 2'd1,
        LEG_ON_L = 2'd2,
        LEG_DEAD = 2'd3
    } leg_state_e;

    // Raw request decode, bit order {h,l}.
    typedef enum logic [1:0] {
        REQ_OFF     = 2'b00,
        REQ_L       = 2'b01,
        REQ_H       = 2'b10,
        REQ_ILLEGAL = 2'b11
    } leg_req_e;

    function automatic leg_req_e decode_req(input logic h, input logic l);
        return leg_req_e'({h, l});
    endfunction

    // State a leg settles into once it is free to follow the request.
    // An illegal request is treated as OFF.
    function automatic leg_state_e settle_state(input leg_req_e req);
        case (req)
            REQ_H:   return LEG_ON_H;
            REQ_L:   return LEG_ON_L;
            default: return LEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/mbldcm_dead_time_inserter_leg.sv
// One half-bridge leg: state machine, dead-time down-counter, sticky fault bit
// and, when MBLDCM_DT_MIN_ON_EN is defined, a minimum-ON hold counter.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  LEG_OFF  | both switches off, follows the next H or L request directly
//  LEG_ON_H | high switch driven
//  LEG_ON_L | low switch driven
//  LEG_DEAD | both switches off for max(dead time,1) clocks, cannot be cut short
module mbldcm_dead_time_leg
    import mbldcm_dead_time_inserter_pkg::*;
#(
    parameter int                    pDeadWidth   = 8,
    parameter logic [pDeadWidth-1:0] pResetDead   = 8'd16
`ifdef MBLDCM_DT_MIN_ON_EN
    ,parameter logic [pDeadWidth-1:0] pMinOnCycles = 8'd4
`endif
)(
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic                  iReqH,
    input  logic                  iReqL,
`ifdef MBLDCM_DT_MIN_ON_EN
    input  logic                  iForceOff,
`endif
    input  logic [pDeadWidth-1:0] iDeadTime,
    input  logic                  iFaultClear,
    output logic                  oH,
    output logic                  oL,
    output logic                  oDead,
    output logic                  oFault
);

    localparam logic [pDeadWidth-1:0] CNT_ONE = {{(pDeadWidth-1){1'b0}}, 1'b1};

    leg_req_e                req;
    leg_state_e              state_q, state_d;
    logic [pDeadWidth-1:0]   cnt_q, cnt_d;
    logic                    fault_q, fault_d;
    logic                    exit_ok;
`ifdef MBLDCM_DT_MIN_ON_EN
    logic [pDeadWidth-1:0]   hold_q, hold_d;
`endif

    // Next-state, dead counter, hold counter and fault decisions.
    always_comb begin
        req     = decode_req(iReqH, iReqL);
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef MBLDCM_DT_MIN_ON_EN
        hold_d  = hold_q;
        // Illegal requests and disable skip the hold so the bridge opens at once.
        exit_ok = (hold_q <= CNT_ONE) || iForceOff || (req == REQ_ILLEGAL);
`else
        exit_ok = 1'b1;
`endif
        case (state_q)
            LEG_OFF: state_d = settle_state(req);
            LEG_ON_H: begin
                if (req != REQ_H && exit_ok) begin
                    state_d = LEG_DEAD;
                    cnt_d   = iDeadTime;
                end
            end
            LEG_ON_L: begin
                if (req != REQ_L && exit_ok) begin
                    state_d = LEG_DEAD;
                    cnt_d   = iDeadTime;
                end
            end
            LEG_DEAD: begin
                if (cnt_q > CNT_ONE) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = settle_state(req);
                end
            end
            default: state_d = LEG_DEAD;
        endcase
`ifdef MBLDCM_DT_MIN_ON_EN
        if ((state_d == LEG_ON_H || state_d == LEG_ON_L) && state_d != state_q) begin
            hold_d = pMinOnCycles;
        end else if ((state_q == LEG_ON_H || state_q == LEG_ON_L) && hold_q > CNT_ONE) begin
            hold_d = hold_q - CNT_ONE;
        end
`endif
        if (req == REQ_ILLEGAL) begin
            fault_d = 1'b1;
        end else if (iFaultClear) begin
            fault_d = 1'b0;
        end else begin
            fault_d = fault_q;
        end
    end

    // State registers; drives are registered from the next state.
    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state_q <= LEG_DEAD;
            cnt_q   <= pResetDead;
            fault_q <= 1'b0;
            oH      <= 1'b0;
            oL      <= 1'b0;
            oDead   <= 1'b1;
`ifdef MBLDCM_DT_MIN_ON_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            oH      <= (state_d == LEG_ON_H);
            oL      <= (state_d == LEG_ON_L);
            oDead   <= (state_d == LEG_DEAD);
`ifdef MBLDCM_DT_MIN_ON_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign oFault = fault_q;

endmodule

// File: rtl/mbldcm_dead_time_inserter.sv
// Dead-time inserter between the BLDC core pulse generators and the gate pads.
// Gates requests with iEnable and fans them out to three identical legs.
// Optional feature macro: MBLDCM_DT_MIN_ON_EN (minimum ON hold per leg).
module mbldcm_dead_time_inserter
    import mbldcm_dead_time_inserter_pkg::*;
#(
    parameter int                    pDeadWidth   = 8,
    parameter logic [pDeadWidth-1:0] pResetDead   = 8'd16
`ifdef MBLDCM_DT_MIN_ON_EN
    ,parameter logic [pDeadWidth-1:0] pMinOnCycles = 8'd4
`endif
)(
    input  logic                  iClock,
    input  logic                  iReset_n,
    input  logic                  iEnable,
    input  logic [pDeadWidth-1:0] iDeadTime,
    input  logic                  iUh,
    input  logic                  iUl,
    input  logic                  iVh,
    input  logic                  iVl,
    input  logic                  iWh,
    input  logic                  iWl,
    input  logic                  iFaultClear,
    output logic                  oUh,
    output logic                  oUl,
    output logic                  oVh,
    output logic                  oVl,
    output logic                  oWh,
    output logic                  oWl,
    output logic [2:0]            oFault,
    output logic [2:0]            oDeadActive
);

    logic [NUM_LEGS-1:0] req_h, req_l, drv_h, drv_l;

    assign req_h[LEG_U] = iUh & iEnable;
    assign req_h[LEG_V] = iVh & iEnable;
    assign req_h[LEG_W] = iWh & iEnable;
    assign req_l[LEG_U] = iUl & iEnable;
    assign req_l[LEG_V] = iVl & iEnable;
    assign req_l[LEG_W] = iWl & iEnable;

    for (genvar g = 0; g < NUM_LEGS; g++) begin : g_leg
        mbldcm_dead_time_leg #(
            .pDeadWidth   (pDeadWidth),
            .pResetDead   (pResetDead)
`ifdef MBLDCM_DT_MIN_ON_EN
            ,.pMinOnCycles (pMinOnCycles)
`endif
        ) u_leg (
            .iClock      (iClock),
            .iReset_n    (iReset_n),
            .iReqH       (req_h[g]),
            .iReqL       (req_l[g]),
`ifdef MBLDCM_DT_MIN_ON_EN
            .iForceOff   (~iEnable),
`endif
            .iDeadTime   (iDeadTime),
            .iFaultClear (iFaultClear),
            .oH          (drv_h[g]),
            .oL          (drv_l[g]),
            .oDead       (oDeadActive[g]),
            .oFault      (oFault[g])
        );
    end

    assign oUh = drv_h[LEG_U];
    assign oUl = drv_l[LEG_U];
    assign oVh = drv_h[LEG_V];
    assign oVl = drv_l[LEG_V];
    assign oWh = drv_h[LEG_W];
    assign oWl = drv_l[LEG_W];

endmodule
